// File: rtl/hazard_scoreboard.sv
// ============================================================================
// hazard_scoreboard : decode-side hazard controller (forwarding, load-use
//                     stall, branch flush/bubble, halt drain, perf counters)
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

module hazard_scoreboard #(
  parameter int ADDR_W      = 5,
  parameter int NUM_SRC     = 3,
  parameter int DEPTH       = 2,
  parameter int LOAD_LAT    = 2,
  parameter int ZERO_REG_EN = 0,
  parameter int CNT_W       = 16,
  parameter int SEL_W       = $clog2(DEPTH + 1)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       id_valid,
  input  logic [NUM_SRC*ADDR_W-1:0]  id_src_addr,
  input  logic [NUM_SRC-1:0]         id_src_used,
  input  logic [ADDR_W-1:0]          id_dst_addr,
  input  logic                       id_dst_wr,
  input  logic                       id_is_load,
  input  logic                       id_halt,
  input  logic                       ex_branch_taken,
  output logic                       stall,
  output logic                       bubble,
  output logic                       flush,
  output logic [NUM_SRC*SEL_W-1:0]   fwd_sel,
  output logic [DEPTH-1:0]           stg_valid,
  output logic                       halted,
  output logic [CNT_W-1:0]           stall_cnt,
  output logic [CNT_W-1:0]           flush_cnt
);

  // Index 0 of every scoreboard vector is S1 (EXE), index DEPTH-1 is WB.
  logic [DEPTH-1:0]             stg_valid_q, stg_valid_d;
  logic [DEPTH-1:0]             stg_wr_q,    stg_wr_d;
  logic [DEPTH-1:0]             stg_load_q,  stg_load_d;
  logic [DEPTH-1:0][ADDR_W-1:0] stg_addr_q,  stg_addr_d;
  logic                         halt_pend_q, halt_pend_d;
  logic [CNT_W-1:0]             stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]             flush_cnt_q, flush_cnt_d;

  logic [NUM_SRC-1:0]             op_haz;
  logic [NUM_SRC-1:0][SEL_W-1:0]  op_sel;
  logic                           any_hazard;

  // Scan oldest to youngest so the youngest matching stage wins.
  always_comb begin
    op_haz  = '0;
    op_sel  = '0;
    fwd_sel = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      for (int k = DEPTH - 1; k >= 0; k--) begin
        if (id_src_used[i] && stg_valid_q[k] && stg_wr_q[k] &&
            (stg_addr_q[k] == id_src_addr[i*ADDR_W +: ADDR_W]) &&
            !((ZERO_REG_EN != 0) && (stg_addr_q[k] == '0))) begin
          if (stg_load_q[k] && ((k + 1) < LOAD_LAT)) begin
            op_haz[i] = 1'b1;
            op_sel[i] = '0;
          end else begin
            op_haz[i] = 1'b0;
            op_sel[i] = SEL_W'(k + 1);
          end
        end
      end
      fwd_sel[i*SEL_W +: SEL_W] = op_sel[i];
    end
  end

  assign any_hazard = |op_haz;
  assign flush      = ex_branch_taken & stg_valid_q[0];
  assign stall      = (id_valid & any_hazard & ~flush) | halt_pend_q;
  assign bubble     = ~id_valid | stall | flush | halt_pend_q;
  assign halted     = halt_pend_q & ~(|stg_valid_q);
  assign stg_valid  = stg_valid_q;
  assign stall_cnt  = stall_cnt_q;
  assign flush_cnt  = flush_cnt_q;

  always_comb begin
    stg_valid_d = '0;
    stg_wr_d    = '0;
    stg_load_d  = '0;
    stg_addr_d  = '0;
    for (int k = 1; k < DEPTH; k++) begin
      stg_valid_d[k] = stg_valid_q[k-1];
      stg_wr_d[k]    = stg_wr_q[k-1];
      stg_load_d[k]  = stg_load_q[k-1];
      stg_addr_d[k]  = stg_addr_q[k-1];
    end
    if (!bubble) begin
      stg_valid_d[0] = 1'b1;
      stg_wr_d[0]    = id_dst_wr;
      stg_load_d[0]  = id_is_load;
      stg_addr_d[0]  = id_dst_addr;
    end

    halt_pend_d = halt_pend_q | (id_valid & id_halt & ~bubble);

    stall_cnt_d = stall_cnt_q;
    if (stall && !(&stall_cnt_q)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
    flush_cnt_d = flush_cnt_q;
    if (flush && !(&flush_cnt_q)) flush_cnt_d = flush_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stg_valid_q <= '0;
      stg_wr_q    <= '0;
      stg_load_q  <= '0;
      stg_addr_q  <= '0;
      halt_pend_q <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stg_valid_q <= stg_valid_d;
      stg_wr_q    <= stg_wr_d;
      stg_load_q  <= stg_load_d;
      stg_addr_q  <= stg_addr_d;
      halt_pend_q <= halt_pend_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

endmodule

`default_nettype wire
